// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory: self-clears to FILL after reset, accepts a streamed program,
// then serves registered, stallable fetches to the PC/fetch stage.
module inst_mem_loadable #(
    parameter int unsigned       ADDR_W = 8,
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       DEPTH  = 256,
    parameter logic [DATA_W-1:0] FILL   = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    input  logic              reload_i,
    output logic [ADDR_W:0]   prog_len_o,
    output logic              run_o,
    input  logic              fetch_en_i,
    input  logic              stall_i,
    input  logic [ADDR_W-1:0] address_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o
);

    localparam int unsigned    IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {StClear, StLoad, StRun} state_e;

    state_e            state_q;
    logic [ADDR_W:0]   clr_cnt_q;
    logic [ADDR_W:0]   wptr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W:0]   mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              ld_accept;
    logic              addr_in_range;
    logic [DATA_W-1:0] rd_word;

    assign ld_accept     = (state_q == StLoad) && ld_valid_i && ld_ready_o;
    assign addr_in_range = {1'b0, address_i} < DEPTH_CNT;
    assign rd_word       = addr_in_range ? mem[address_i[IDX_W-1:0]] : FILL;

    // Single write port shared by the clear sweep and the program load.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = FILL;
        if (!reset) begin
            if (state_q == StClear) begin
                mem_we = 1'b1;
            end else if (ld_accept) begin
                mem_we    = 1'b1;
                mem_waddr = wptr_q;
                mem_wdata = ld_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StClear;
            clr_cnt_q    <= '0;
            wptr_q       <= '0;
            prog_len_o   <= '0;
            ld_ready_o   <= 1'b0;
            run_o        <= 1'b0;
            data_o       <= FILL;
            data_valid_o <= 1'b0;
        end else begin
            unique case (state_q)
                StClear: begin
                    data_valid_o <= 1'b0;
                    clr_cnt_q    <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_IDX) begin
                        state_q    <= StLoad;
                        ld_ready_o <= 1'b1;
                    end
                end
                StLoad: begin
                    data_valid_o <= 1'b0;
                    if (ld_accept) begin
                        wptr_q     <= wptr_q + 1'b1;
                        prog_len_o <= wptr_q + 1'b1;
                        // Leaving on a full memory guarantees no word lands past DEPTH-1.
                        if (ld_last_i || (wptr_q == LAST_IDX)) begin
                            state_q    <= StRun;
                            ld_ready_o <= 1'b0;
                            run_o      <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (reload_i) begin
                        state_q      <= StLoad;
                        wptr_q       <= '0;
                        prog_len_o   <= '0;
                        ld_ready_o   <= 1'b1;
                        run_o        <= 1'b0;
                        data_valid_o <= 1'b0;
                    end else if (!stall_i) begin
                        if (fetch_en_i) begin
                            data_o       <= rd_word;
                            data_valid_o <= 1'b1;
                        end else begin
                            data_valid_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StClear;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Directed bench for inst_mem_loadable with DEPTH=16: clear, load, fetch, stall, overflow, reset.
module tb_inst_mem_loadable;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_valid_i;
    logic [DATA_W-1:0] ld_data_i;
    logic              ld_last_i;
    logic              ld_ready_o;
    logic              reload_i;
    logic [ADDR_W:0]   prog_len_o;
    logic              run_o;
    logic              fetch_en_i;
    logic              stall_i;
    logic [ADDR_W-1:0] address_i;
    logic [DATA_W-1:0] data_o;
    logic              data_valid_o;

    int checks = 0;
    int errors = 0;

    inst_mem_loadable #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .FILL  (8'hFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_valid_i  (ld_valid_i),
        .ld_data_i   (ld_data_i),
        .ld_last_i   (ld_last_i),
        .ld_ready_o  (ld_ready_o),
        .reload_i    (reload_i),
        .prog_len_o  (prog_len_o),
        .run_o       (run_o),
        .fetch_en_i  (fetch_en_i),
        .stall_i     (stall_i),
        .address_i   (address_i),
        .data_o      (data_o),
        .data_valid_o(data_valid_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_prog_len"}, 32'(prog_len_o), 32'd0);
        check({tag, "_ld_ready"}, 32'(ld_ready_o), 32'd0);
        check({tag, "_run"}, 32'(run_o), 32'd0);
        check({tag, "_data"}, 32'(data_o), 32'hFF);
        check({tag, "_valid"}, 32'(data_valid_o), 32'd0);
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] addr);
        fetch_en_i = 1'b1;
        address_i  = addr;
        tick();
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        ld_valid_i = 1'b0;
        ld_data_i  = '0;
        ld_last_i  = 1'b0;
        reload_i   = 1'b0;
        fetch_en_i = 1'b0;
        stall_i    = 1'b0;
        address_i  = '0;

        // T1: reset state, then exactly DEPTH cycles of clear before LOAD.
        tick();
        check_reset_outputs("t1_reset");
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("t1_clear_busy%0d", i), {30'd0, ld_ready_o, run_o}, 32'd0);
        end
        tick();
        check("t1_ld_ready", 32'(ld_ready_o), 32'd1);
        check("t1_run", 32'(run_o), 32'd0);

        // T2: three-word program, then fetches with one-cycle latency.
        ld_valid_i = 1'b1;
        ld_data_i  = 8'h10;
        tick();
        ld_data_i  = 8'h11;
        tick();
        ld_data_i  = 8'h12;
        ld_last_i  = 1'b1;
        tick();
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
        check("t2_run", 32'(run_o), 32'd1);
        check("t2_ld_ready", 32'(ld_ready_o), 32'd0);
        check("t2_prog_len", 32'(prog_len_o), 32'd3);
        check("t2_valid_idle", 32'(data_valid_o), 32'd0);
        fetch(8'd0);
        check("t2_data0", 32'(data_o), 32'h10);
        check("t2_valid0", 32'(data_valid_o), 32'd1);
        fetch(8'd1);
        check("t2_data1", 32'(data_o), 32'h11);
        fetch(8'd2);
        check("t2_data2", 32'(data_o), 32'h12);
        fetch(8'd3);
        check("t2_data3", 32'(data_o), 32'hFF);
        check("t2_valid3", 32'(data_valid_o), 32'd1);
        fetch_en_i = 1'b0;
        tick();
        check("t2_idle_valid", 32'(data_valid_o), 32'd0);
        check("t2_idle_hold", 32'(data_o), 32'hFF);

        // T3: out-of-range fetch returns FILL.
        fetch(8'd0);
        check("t3_pre", 32'(data_o), 32'h10);
        fetch(8'd20);
        check("t3_oob_data", 32'(data_o), 32'hFF);
        check("t3_oob_valid", 32'(data_valid_o), 32'd1);

        // T4: stall holds the previous result even with a new address presented.
        fetch(8'd1);
        check("t4_pre", 32'(data_o), 32'h11);
        stall_i   = 1'b1;
        address_i = 8'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t4_stall_data%0d", i), 32'(data_o), 32'h11);
            check($sformatf("t4_stall_valid%0d", i), 32'(data_valid_o), 32'd1);
        end
        stall_i = 1'b0;
        tick();
        check("t4_after_stall", 32'(data_o), 32'h12);
        fetch_en_i = 1'b0;
        tick();

        // T5: reload, then stream 17 words without last; memory fills at 16.
        reload_i = 1'b1;
        tick();
        reload_i = 1'b0;
        check("t5_reload_ready", 32'(ld_ready_o), 32'd1);
        check("t5_reload_run", 32'(run_o), 32'd0);
        check("t5_reload_len", 32'(prog_len_o), 32'd0);
        ld_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ld_data_i = 8'(8'h20 + i);
            tick();
            if (i == 14) check("t5_still_loading", 32'(ld_ready_o), 32'd1);
        end
        check("t5_full_run", 32'(run_o), 32'd1);
        check("t5_full_len", 32'(prog_len_o), 32'd16);
        ld_data_i = 8'h30;
        tick();
        ld_valid_i = 1'b0;
        check("t5_17th_len", 32'(prog_len_o), 32'd16);
        check("t5_17th_run", 32'(run_o), 32'd1);
        fetch(8'd15);
        check("t5_word15", 32'(data_o), 32'h2F);
        fetch(8'd0);
        check("t5_word0", 32'(data_o), 32'h20);
        fetch(8'd3);
        check("t5_word3", 32'(data_o), 32'h23);
        fetch_en_i = 1'b0;
        tick();

        // T6: reset mid-load wipes state and contents; a fresh one-word load is fetchable.
        reload_i = 1'b1;
        tick();
        reload_i   = 1'b0;
        ld_valid_i = 1'b1;
        ld_data_i  = 8'h55;
        tick();
        ld_data_i  = 8'h66;
        tick();
        ld_data_i  = 8'h77;
        reset      = 1'b1;
        tick();
        check_reset_outputs("t6_reset");
        reset      = 1'b0;
        ld_valid_i = 1'b0;
        n = 0;
        while (!ld_ready_o && n < 40) begin
            tick();
            n++;
        end
        check("t6_clear_cycles", 32'(n), 32'd16);
        ld_valid_i = 1'b1;
        ld_last_i  = 1'b1;
        ld_data_i  = 8'hA5;
        tick();
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
        check("t6_run", 32'(run_o), 32'd1);
        check("t6_len", 32'(prog_len_o), 32'd1);
        fetch(8'd0);
        check("t6_word0", 32'(data_o), 32'hA5);
        fetch(8'd1);
        check("t6_word1_cleared", 32'(data_o), 32'hFF);
        fetch_en_i = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
